ram_arbiter: RTL

- Shares the single-port data RAM between two requesters:
  - port 0: processor control unit.
  - port 1: I/O / program-loader engine.
- Uses a registered req/ack handshake per port.
- Sits between the requesters and the RAM/MDR side of the datapath and sequences every RAM access: latch, drive, wait for latency, capture, acknowledge.
- Round-robin fairness, with a lock input that lets port 0 perform atomic read-modify-write sequences.

---
 rtl/karp_mem_pkg.sv | 15 +
 rtl/ram_arbiter_rr_pick2.sv | 31 +++
 rtl/ram_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/karp_mem_pkg.sv
// Shared types and constants for the data-RAM arbiter.
package karp_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_IO     = 1'b1;
    localparam int   RAM_LAT_MAX = 7;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; lock_only restricts eligibility to the CPU port.
module rr_pick2
    import karp_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock_only,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = PORT_CPU;
        if (lock_only) begin
            gnt_valid = req[PORT_CPU];
            gnt_id    = PORT_CPU;
        end else if (req == 2'b11) begin
            // On a tie the port that was not served last goes first.
            gnt_valid = 1'b1;
            gnt_id    = ~last;
        end else if (req[PORT_IO]) begin
            gnt_valid = 1'b1;
            gnt_id    = PORT_IO;
        end else if (req[PORT_CPU]) begin
            gnt_valid = 1'b1;
            gnt_id    = PORT_CPU;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the control unit (port 0) and the I/O loader (port 1).
// Each access runs IDLE -> ACCESS -> WAIT(RAM_LAT cycles) -> DONE; all outputs are registered.
module ram_arbiter
    import karp_mem_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock0,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              owner,
    output logic              busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output arb_state_t        dbg_state
);

    // Handshake: req[i] rises and is held (with we/addr/wdata stable) until ack[i]
    // pulses for one cycle; the requester drops req at the edge ending that cycle.
    // Inputs are only sampled in IDLE, so changes mid-transaction are ignored.

    localparam int              LAT_W    = $clog2(RAM_LAT_MAX + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RAM_LAT);

    arb_state_t        state, state_nxt;
    logic              rr_last, rr_last_nxt;
    logic              locked, locked_nxt;
    logic              acc_we, acc_we_nxt;
    logic [LAT_W-1:0]  lat_cnt, lat_cnt_nxt;
    logic [1:0]        ack_nxt;
    logic [DATA_W-1:0] rdata_nxt;
    logic              owner_nxt;
    logic              busy_nxt;
    logic              ram_en_nxt;
    logic              ram_we_nxt;
    logic [ADDR_W-1:0] ram_addr_nxt;
    logic [DATA_W-1:0] ram_wdata_nxt;

    logic              lock_only;
    logic              gnt_valid;
    logic              gnt_id;

    // lock0 low in an idle cycle releases the lock and arbitrates normally in that same cycle.
    assign lock_only = locked & lock0;
    assign dbg_state = state;

    rr_pick2 u_pick (
        .req       (req),
        .last      (rr_last),
        .lock_only (lock_only),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        state_nxt     = state;
        rr_last_nxt   = rr_last;
        locked_nxt    = locked;
        acc_we_nxt    = acc_we;
        lat_cnt_nxt   = lat_cnt;
        ack_nxt       = 2'b00;
        rdata_nxt     = rdata;
        owner_nxt     = owner;
        ram_en_nxt    = 1'b0;
        ram_we_nxt    = 1'b0;
        ram_addr_nxt  = ram_addr;
        ram_wdata_nxt = ram_wdata;

        unique case (state)
            IDLE: begin
                locked_nxt  = lock_only;
                lat_cnt_nxt = '0;
                if (gnt_valid) begin
                    state_nxt     = ACCESS;
                    owner_nxt     = gnt_id;
                    acc_we_nxt    = we[gnt_id];
                    ram_en_nxt    = 1'b1;
                    ram_we_nxt    = we[gnt_id];
                    ram_addr_nxt  = (gnt_id == PORT_IO) ? addr1 : addr0;
                    ram_wdata_nxt = (gnt_id == PORT_IO) ? wdata1 : wdata0;
                end
            end
            ACCESS: begin
                state_nxt   = WAIT;
                lat_cnt_nxt = LAT_W'(1);
            end
            WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    state_nxt      = DONE;
                    ack_nxt[owner] = 1'b1;
                    if (!acc_we) begin
                        rdata_nxt = ram_rdata;
                    end
                end else begin
                    lat_cnt_nxt = lat_cnt + 1'b1;
                end
            end
            DONE: begin
                state_nxt   = IDLE;
                rr_last_nxt = owner;
                locked_nxt  = (owner == PORT_CPU) & lock0;
                lat_cnt_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            rr_last   <= PORT_IO;
            locked    <= 1'b0;
            acc_we    <= 1'b0;
            lat_cnt   <= '0;
            ack       <= 2'b00;
            rdata     <= '0;
            owner     <= PORT_CPU;
            busy      <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state     <= state_nxt;
            rr_last   <= rr_last_nxt;
            locked    <= locked_nxt;
            acc_we    <= acc_we_nxt;
            lat_cnt   <= lat_cnt_nxt;
            ack       <= ack_nxt;
            rdata     <= rdata_nxt;
            owner     <= owner_nxt;
            busy      <= busy_nxt;
            ram_en    <= ram_en_nxt;
            ram_we    <= ram_we_nxt;
            ram_addr  <= ram_addr_nxt;
            ram_wdata <= ram_wdata_nxt;
        end
    end

endmodule
